sm_to_twos_serial: RTL and testbench
====================================

SM_TO_TWOS_SERIAL -- requirements
Module: sm_to_twos_serial

Interface
REQ-001 Parameter: N, default 8, total word width (1 sign bit plus N-1 magnitude bits); legal N >= 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_data holds a word to convert.
REQ-005 in_ready  output  1  block can accept a word (high only in IDLE).
REQ-006 in_data  input  N  sign-magnitude word; bit N-1 is the sign, bits N-2:0 are the magnitude.
REQ-007 out_valid  output  1  out_data holds a completed result (high only in DONE).
REQ-008 out_ready  input  1  consumer accepts out_data.
REQ-009 out_data  output  N  two's-complement result.
REQ-010 neg_zero  output  1  result came from -0 input; present only when SM2C_NEGZERO_EN is defined.

Function
REQ-011 FSM states: IDLE, CONV, DONE; the design shall have no other reachable state.
REQ-012 IDLE: in_ready=1; on in_valid&in_ready at edge k, latch sign and magnitude, clear bit index and seen_one, go to CONV.
REQ-013 CONV: process one magnitude bit per cycle, LSB first: out_bit = mag_bit XOR (sign AND seen_one), then seen_one |= mag_bit.
REQ-014 CONV shall last exactly N-1 cycles (bits 0..N-2); DONE shall be entered at edge k+N-1 (7 cycles for N=8).
REQ-015 Result MSB: out_data[N-1] = sign AND (magnitude != 0).
REQ-016 Negative zero (sign=1, magnitude=0) shall produce out_data = 0.
REQ-017 The output range is always representable (|value| <= 2^(N-1)-1); no overflow condition exists.
REQ-018 DONE: out_valid=1 and out_data stable; hold indefinitely while out_ready=0.
REQ-019 In DONE, out_valid&out_ready at an edge shall transition to IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-020 in_valid and in_data shall be ignored outside IDLE; in_data changes during CONV shall not affect the result.
REQ-021 Throughput: at most one word per N+1 cycles with out_ready held high.

Reset
REQ-022 rst_n=0 at an edge shall force IDLE from any state, including mid-CONV, and discard any partial result.
REQ-023 Reset values: in_ready=1 (after the reset edge), out_valid=0, out_data=0, neg_zero=0, bit index=0, seen_one=0.

Configuration
REQ-024 Macro SM2C_NEGZERO_EN defined: neg_zero port exists; high during DONE iff the latched word was sign=1, magnitude=0; otherwise low.
REQ-025 Macro SM2C_NEGZERO_EN undefined: neg_zero port and its logic are absent; all other behaviour is identical.

Structure
REQ-026 Shared package sm2c_pkg shall hold the FSM state enum (IDLE/CONV/DONE) and the default width constant SM2C_N_DEFAULT = 8.
REQ-027 Per-bit logic shall be a sub-module twos_bit_cell (inputs mag_bit, sign, seen_in; outputs out_bit, seen_out); the FSM, shift register, and index counter stay in sm_to_twos_serial.

Verification (N=8)
REQ-028 in_data=0x85 (-5) accepted -> out_valid after 7 cycles with out_data=0xFB.
REQ-029 in_data=0x05 -> out_data=0x05; in_data=0xFF (-127) -> out_data=0x81; in_data=0x7F -> 0x7F.
REQ-030 in_data=0x80 (-0) -> out_data=0x00, with neg_zero=1 when SM2C_NEGZERO_EN is defined.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data held; in_ready stays 0; release -> IDLE next cycle.
REQ-032 Reset mid-CONV (rst_n=0 at cycle 3 after accept) -> next cycle IDLE with out_valid=0; the next word 0x83 converts to 0xFD.
REQ-033 Back-to-back words (0x81, 0x01) with in_valid held high -> results 0xFF then 0x01, second accept no earlier than 1 cycle after the first output handshake.

Source files
------------

// File: rtl/sm2c_pkg.sv
// Shared definitions for the serial sign-magnitude to two's-complement converter.
//   SM2C_N_DEFAULT : default total word width (sign bit + magnitude bits)
//   sm2c_state_e   : converter FSM states
package sm2c_pkg;

    localparam int SM2C_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } sm2c_state_e;

endpackage

// File: rtl/twos_bit_cell.sv
// One bit of the serial negate: for a negative word, every magnitude bit
// above the lowest set bit is inverted; bits up to and including it pass.
//   mag_bit  : current magnitude bit (LSB first)
//   sign     : latched sign of the word
//   seen_in  : a 1 has already appeared in lower magnitude bits
//   out_bit  : converted result bit
//   seen_out : updated "seen a 1" flag for the next bit
module twos_bit_cell (
    input  logic mag_bit,
    input  logic sign,
    input  logic seen_in,
    output logic out_bit,
    output logic seen_out
);

    assign out_bit  = mag_bit ^ (sign & seen_in);
    assign seen_out = seen_in | mag_bit;

endmodule

// File: rtl/sm_to_twos_serial.sv
// Serial sign-magnitude to two's-complement converter, one magnitude bit per
// cycle, LSB first, with a valid/ready handshake on both sides.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake (ready only while IDLE)
//   in_data   [N-1:0]    : sign-magnitude word, bit N-1 is the sign
//   out_valid/out_ready  : output handshake (valid only while DONE)
//   out_data  [N-1:0]    : two's-complement result
//   neg_zero             : result came from a -0 input (only when the
//                          SM2C_NEGZERO_EN macro is defined)
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// CONV  | converting magnitude bits 0..N-2, one per cycle
// DONE  | result presented, held until out_ready
module sm_to_twos_serial
    import sm2c_pkg::*;
#(
    parameter int N = SM2C_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
`ifdef SM2C_NEGZERO_EN
    ,
    output logic         neg_zero
`endif
);

    localparam int MW    = N - 1;
    localparam int IDX_W = (MW > 1) ? $clog2(MW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MW - 1);

    sm2c_state_e state_q, state_d;

    logic             sign_q;
    logic [MW-1:0]    mag_q;
    logic [MW-1:0]    res_q;
    logic [MW:0]      res_shift;
    logic [IDX_W-1:0] idx_q;
    logic             seen_q;
    logic             cell_out;
    logic             cell_seen;
    logic             accept;
    logic             conv_last;

    twos_bit_cell u_cell (
        .mag_bit  (mag_q[0]),
        .sign     (sign_q),
        .seen_in  (seen_q),
        .out_bit  (cell_out),
        .seen_out (cell_seen)
    );

    assign accept    = (state_q == IDLE) && in_valid;
    assign conv_last = (state_q == CONV) && (idx_q == IDX_LAST);
    // Result bits enter at the top and walk down, so bit 0 lands last at LSB.
    assign res_shift = {cell_out, res_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = CONV;
            CONV:    if (conv_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            res_q  <= '0;
            idx_q  <= '0;
            seen_q <= 1'b0;
        end else if (accept) begin
            sign_q <= in_data[N-1];
            mag_q  <= in_data[MW-1:0];
            res_q  <= '0;
            idx_q  <= '0;
            seen_q <= 1'b0;
        end else if (state_q == CONV) begin
            mag_q  <= mag_q >> 1;
            res_q  <= res_shift[MW:1];
            idx_q  <= idx_q + IDX_W'(1);
            seen_q <= cell_seen;
        end
    end

    // After the last bit, seen_q is exactly (magnitude != 0), which also
    // forces the -0 case to a plain zero.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = {sign_q & seen_q, res_q};
`ifdef SM2C_NEGZERO_EN
        neg_zero  = (state_q == DONE) && sign_q && !seen_q;
`endif
    end

endmodule

// File: tb/tb_sm_to_twos_serial.sv
module tb_sm_to_twos_serial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_data;
`ifdef SM2C_NEGZERO_EN
    logic         neg_zero;
`endif

    sm_to_twos_serial #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SM2C_NEGZERO_EN
        ,
        .neg_zero  (neg_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         nz;
        int           acc_edge;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_hs = -1;
    bit   rand_ready = 1'b0;
    bit   prev_valid = 1'b0;
    logic [N-1:0] held_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: signed value of the sign-magnitude word, wrapped to N bits.
    function automatic logic [N-1:0] model(input logic [N-1:0] w);
        int mag;
        int v;
        mag = int'(w[N-2:0]);
        v = w[N-1] ? -mag : mag;
        return v[N-1:0];
    endfunction

    function automatic logic model_nz(input logic [N-1:0] w);
        return w[N-1] && (w[N-2:0] == '0);
    endfunction

    task automatic send_word(input logic [N-1:0] w, input logic [N-1:0] exp, input bit hold);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(waited), 32'd0);
            in_valid = 1'b0;
        end else begin
            e.data = exp;
            e.nz = model_nz(w);
            e.acc_edge = cyc + 1;
            if (last_hs >= 0) chk("accept_after_handshake", 32'(e.acc_edge > last_hs), 32'd1);
            sb.push_back(e);
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            in_data = N'($urandom);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("latency", 32'(cyc - sb[0].acc_edge), 32'(N - 1));
                    chk("out_data", 32'(out_data), 32'(sb[0].data));
`ifdef SM2C_NEGZERO_EN
                    chk("neg_zero", 32'(neg_zero), 32'(sb[0].nz));
`endif
                end
                held_data = out_data;
            end else if (out_valid && prev_valid) begin
                chk("hold_data", 32'(out_data), 32'(held_data));
            end
            if (out_valid) chk("in_ready_while_done", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                last_hs = cyc + 1;
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int n;
        logic [N-1:0] w;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef SM2C_NEGZERO_EN
        chk("rst_neg_zero", 32'(neg_zero), 32'd0);
`endif

        // Directed vectors with literal expectations
        send_word(8'h85, 8'hFB, 1'b0);
        send_word(8'h05, 8'h05, 1'b0);
        send_word(8'hFF, 8'h81, 1'b0);
        send_word(8'h7F, 8'h7F, 1'b0);
        send_word(8'h80, 8'h00, 1'b0);
        send_word(8'h00, 8'h00, 1'b0);
        wait_drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        send_word(8'h85, 8'hFB, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_data_held", 32'(out_data), 32'hFB);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        wait_drain();

        // Reset mid-CONV: reset sampled at the third edge after accept
        send_word(8'h85, 8'hFB, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        send_word(8'h83, 8'hFD, 1'b0);
        wait_drain();

        // Back-to-back with in_valid held high
        send_word(8'h81, 8'hFF, 1'b1);
        send_word(8'h01, 8'h01, 1'b0);
        wait_drain();

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = N'($urandom);
            if (i % 8 == 3) w = 8'h80;
            if (i % 8 == 6) w = 8'h00;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(w, model(w), 1'b0);
        end
        wait_drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
